// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller: moves,
// round results, match winner codes and the controller FSM state.
package rps_pkg;

    localparam logic [2:0] ROCK     = 3'b001;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b100;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_JUDGE   = 3'd2,
        ST_REPORT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic is_one_hot(input logic [2:0] m);
        return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_judge_core.sv
// Combinational RPS judge: compares two one-hot moves. Non-one-hot inputs
// produce no outcome (all flags low).
module rps_judge_core
    import rps_pkg::*;
(
    input  logic [2:0] p1_move,
    input  logic [2:0] p2_move,
    output logic       p1_wins,
    output logic       p2_wins,
    output logic       tied
);

    logic both_legal;

    always_comb begin
        both_legal = is_one_hot(p1_move) && is_one_hot(p2_move);
        p1_wins = both_legal &&
                  (((p1_move == ROCK)     && (p2_move == SCISSORS)) ||
                   ((p1_move == PAPER)    && (p2_move == ROCK))     ||
                   ((p1_move == SCISSORS) && (p2_move == PAPER)));
        tied    = both_legal && (p1_move == p2_move);
        p2_wins = both_legal && !p1_wins && !tied;
    end

endmodule

// File: rtl/rps_match_controller.sv
// Multi-round rock-paper-scissors match sequencer around rps_judge_core.
// Optional collection timeout with forfeit: define RPS_ROUND_TIMEOUT_EN.
module rps_match_controller
    import rps_pkg::*;
#(
    parameter int WIN_TARGET     = 3,
    parameter int MAX_ROUNDS     = 15,
    parameter int SCORE_W        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         p1_move,
    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic [2:0]         p2_move,
    input  logic               p2_valid,
    output logic               p2_ready,
    output logic [1:0]         bad_move,
    output logic               round_done,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] round_count,
    output logic               match_done,
    output logic [1:0]         match_winner,
    output state_t             fsm_state
);

    // Handshake: a move transfers on a cycle where valid and ready are both
    // high; it is latched only if one-hot, otherwise bad_move pulses next
    // cycle and ready stays high so the player can retry.

    if (WIN_TARGET < 1 || WIN_TARGET >= (1 << SCORE_W) ||
        MAX_ROUNDS < 1 || MAX_ROUNDS >= (1 << SCORE_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rps_match_controller: WIN_TARGET/MAX_ROUNDS must be in 1..2^SCORE_W-1, TIMEOUT_CYCLES >= 1");
    end

    localparam logic [SCORE_W-1:0] WIN_T   = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] MAX_R   = SCORE_W'(MAX_ROUNDS);
    localparam logic [SCORE_W-1:0] CNT_MAX = '1;

    state_t     state_q, state_next;
    logic [2:0] p1_mv_q, p2_mv_q;
    logic       p1_have_q, p2_have_q;
    logic       p1_accept, p2_accept, p1_bad, p2_bad;
    logic       j_p1, j_p2, j_tie;
    logic [1:0] judged;
    logic       new_match;

`ifdef RPS_ROUND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_T = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_hit;
    assign timeout_hit = (to_cnt_q == TO_T);
`endif

    rps_judge_core u_judge (
        .p1_move (p1_mv_q),
        .p2_move (p2_mv_q),
        .p1_wins (j_p1),
        .p2_wins (j_p2),
        .tied    (j_tie)
    );

    assign p1_ready   = (state_q == ST_COLLECT) && !p1_have_q;
    assign p2_ready   = (state_q == ST_COLLECT) && !p2_have_q;
    assign round_done = (state_q == ST_REPORT);
    assign match_done = (state_q == ST_DONE);
    assign fsm_state  = state_q;
    assign new_match  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_next = state_q;
        p1_accept  = 1'b0;
        p2_accept  = 1'b0;
        p1_bad     = 1'b0;
        p2_bad     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_next = ST_COLLECT;
            ST_COLLECT: begin
                p1_accept = p1_valid && p1_ready && is_one_hot(p1_move);
                p2_accept = p2_valid && p2_ready && is_one_hot(p2_move);
                p1_bad    = p1_valid && p1_ready && !is_one_hot(p1_move);
                p2_bad    = p2_valid && p2_ready && !is_one_hot(p2_move);
                if ((p1_have_q || p1_accept) && (p2_have_q || p2_accept))
                    state_next = ST_JUDGE;
`ifdef RPS_ROUND_TIMEOUT_EN
                else if (timeout_hit)
                    state_next = ST_JUDGE;
`endif
            end
            ST_JUDGE: state_next = ST_REPORT;
            ST_REPORT: begin
                if ((p1_score == WIN_T) || (p2_score == WIN_T) || (round_count == MAX_R))
                    state_next = ST_DONE;
                else
                    state_next = ST_COLLECT;
            end
            ST_DONE: if (start) state_next = ST_COLLECT;
            default: state_next = ST_IDLE;
        endcase
    end

    // A round with a missing move can only reach JUDGE through the timeout:
    // the lone submitter wins by forfeit, no submitter means a tie.
    always_comb begin
        judged = RES_TIE;
        if (p1_have_q && p2_have_q)
            judged = j_p1 ? RES_P1 : (j_p2 ? RES_P2 : (j_tie ? RES_TIE : RES_NONE));
        else if (p1_have_q)
            judged = RES_P1;
        else if (p2_have_q)
            judged = RES_P2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p1_mv_q      <= '0;
            p2_mv_q      <= '0;
            p1_have_q    <= 1'b0;
            p2_have_q    <= 1'b0;
            bad_move     <= '0;
            round_result <= RES_NONE;
            p1_score     <= '0;
            p2_score     <= '0;
            round_count  <= '0;
            match_winner <= WIN_NONE;
        end else begin
            state_q  <= state_next;
            bad_move <= {p2_bad, p1_bad};
            if (new_match) begin
                p1_mv_q      <= '0;
                p2_mv_q      <= '0;
                p1_have_q    <= 1'b0;
                p2_have_q    <= 1'b0;
                round_result <= RES_NONE;
                p1_score     <= '0;
                p2_score     <= '0;
                round_count  <= '0;
                match_winner <= WIN_NONE;
            end
            if (p1_accept) begin
                p1_mv_q   <= p1_move;
                p1_have_q <= 1'b1;
            end
            if (p2_accept) begin
                p2_mv_q   <= p2_move;
                p2_have_q <= 1'b1;
            end
            if (state_q == ST_JUDGE) begin
                round_result <= judged;
                if (judged == RES_P1 && p1_score != CNT_MAX) p1_score <= p1_score + 1'b1;
                if (judged == RES_P2 && p2_score != CNT_MAX) p2_score <= p2_score + 1'b1;
                if (round_count != CNT_MAX) round_count <= round_count + 1'b1;
            end
            if (state_q == ST_REPORT) begin
                p1_mv_q   <= '0;
                p2_mv_q   <= '0;
                p1_have_q <= 1'b0;
                p2_have_q <= 1'b0;
                if (p1_score == WIN_T)
                    match_winner <= WIN_P1;
                else if (p2_score == WIN_T)
                    match_winner <= WIN_P2;
                else if (round_count == MAX_R)
                    match_winner <= (p1_score > p2_score) ? WIN_P1 :
                                    (p2_score > p1_score) ? WIN_P2 : WIN_DRAW;
            end
        end
    end

`ifdef RPS_ROUND_TIMEOUT_EN
    // Counter restarts on every entry to COLLECT because it idles at zero elsewhere.
    always_ff @(posedge clock) begin
        if (reset || state_q != ST_COLLECT)
            to_cnt_q <= '0;
        else if (!timeout_hit)
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed-vector bench for rps_match_controller (WIN_TARGET=3, MAX_ROUNDS=4,
// TIMEOUT_CYCLES=8); timeout rounds run only when RPS_ROUND_TIMEOUT_EN is set.
module tb_rps_match_controller;
    import rps_pkg::*;

    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    p1_move, p2_move;
    logic          p1_valid, p2_valid;
    logic          p1_ready, p2_ready;
    logic [1:0]    bad_move;
    logic          round_done;
    logic [1:0]    round_result;
    logic [SW-1:0] p1_score, p2_score, round_count;
    logic          match_done;
    logic [1:0]    match_winner;
    state_t        fsm_state;

    int num_checks = 0;
    int num_errors = 0;

    rps_match_controller #(
        .WIN_TARGET(3), .MAX_ROUNDS(4), .SCORE_W(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
        .bad_move(bad_move), .round_done(round_done), .round_result(round_result),
        .p1_score(p1_score), .p2_score(p2_score), .round_count(round_count),
        .match_done(match_done), .match_winner(match_winner), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Both moves presented in one cycle; REPORT is checked, then one more edge.
    task automatic do_round(input logic [2:0] m1, input logic [2:0] m2, input logic [1:0] exp_res,
                            input int e1, input int e2, input int ec);
        p1_move = m1; p2_move = m2; p1_valid = 1'b1; p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        check("judge_no_done", round_done, 1'b0);
        tick();
        check("round_done", round_done, 1'b1);
        check("round_result", round_result, exp_res);
        check("p1_score", p1_score, e1);
        check("p2_score", p2_score, e2);
        check("round_count", round_count, ec);
        tick();
    endtask

    task automatic wait_round_done(input int budget);
        int n = 0;
        while (!round_done && n < budget) begin
            tick();
            n++;
        end
        check("round_done_seen", round_done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        p1_move = '0; p2_move = '0; p1_valid = 1'b0; p2_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_readies", {p1_ready, p2_ready}, 2'b00);
        check("rst_outputs", {bad_move, round_done, round_result, match_done, match_winner}, 8'h00);
        check("rst_counts", {p1_score, p2_score, round_count}, 12'h000);

        // Reset in the middle of collection discards p1's latched move.
        pulse_start();
        check("collect_entry", fsm_state, ST_COLLECT);
        check("collect_readies", {p1_ready, p2_ready}, 2'b11);
        p1_move = ROCK; p1_valid = 1'b1;
        tick();
        p1_valid = 1'b0;
        check("p1_latched_ready", {p1_ready, p2_ready}, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_state", fsm_state, ST_IDLE);
        check("midrst_readies", {p1_ready, p2_ready}, 2'b00);
        pulse_start();
        p2_move = PAPER; p2_valid = 1'b1;
        tick();
        p2_valid = 1'b0;
        check("p2_only_ready", {p1_ready, p2_ready}, 2'b10);
        tick(); tick();
        check("p2_only_no_judge", fsm_state, ST_COLLECT);
        check("p2_only_no_done", round_done, 1'b0);
        p1_move = ROCK; p1_valid = 1'b1;
        tick();
        p1_valid = 1'b0;
        check("late_p1_judge", fsm_state, ST_JUDGE);
        tick();
        check("late_round_done", round_done, 1'b1);
        check("late_result", round_result, RES_P2);
        check("late_scores", {p1_score, p2_score, round_count}, 12'h011);
        tick();

        // start is ignored mid-match
        pulse_start();
        check("start_ignored", fsm_state, ST_COLLECT);
        check("start_ignored_cnt", round_count, 1);

        do_round(ROCK, SCISSORS, RES_P1, 1, 1, 2);

        // Illegal moves: pulse, no latch, readies stay up
        p1_move = 3'b011; p2_move = 3'b000; p1_valid = 1'b1; p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        check("bad_both", bad_move, 2'b11);
        check("bad_readies", {p1_ready, p2_ready}, 2'b11);
        tick();
        check("bad_cleared", bad_move, 2'b00);
        p1_move = 3'b011; p1_valid = 1'b1;
        tick();
        check("bad_p1", bad_move, 2'b01);
        check("bad_p1_ready", p1_ready, 1'b1);
        p1_move = PAPER;
        tick();
        p1_valid = 1'b0;
        check("retry_p1_latched", {p1_ready, p2_ready, bad_move}, 4'b0100);
        p2_move = PAPER; p2_valid = 1'b1;
        tick();
        p2_valid = 1'b0;
        check("tie_judge", fsm_state, ST_JUDGE);
        tick();
        check("tie_done", round_done, 1'b1);
        check("tie_result", round_result, RES_TIE);
        check("tie_scores", {p1_score, p2_score, round_count}, 12'h113);
        tick();

        // Fourth round hits MAX_ROUNDS; p2 leads 2-1
        do_round(ROCK, PAPER, RES_P2, 1, 2, 4);
        check("max_done", match_done, 1'b1);
        check("max_winner_p2", match_winner, WIN_P2);
        check("max_result_held", round_result, RES_P2);

        // New match from DONE, p2 reaches WIN_TARGET
        pulse_start();
        check("restart_clear", {p1_score, p2_score, round_count}, 12'h000);
        check("restart_flags", {match_done, match_winner, round_result}, 5'b00000);
        do_round(ROCK, PAPER, RES_P2, 0, 1, 1);
        do_round(ROCK, PAPER, RES_P2, 0, 2, 2);
        do_round(ROCK, PAPER, RES_P2, 0, 3, 3);
        check("target_done", match_done, 1'b1);
        check("target_winner", match_winner, WIN_P2);
        tick();
        check("done_held", {p2_score, fsm_state}, {4'd3, ST_DONE});

        // Three ties then a p1 win at MAX_ROUNDS
        pulse_start();
        check("restart2_clear", {p1_score, p2_score, match_winner}, 10'h000);
        do_round(ROCK, ROCK, RES_TIE, 0, 0, 1);
        do_round(PAPER, PAPER, RES_TIE, 0, 0, 2);
        do_round(SCISSORS, SCISSORS, RES_TIE, 0, 0, 3);
        do_round(PAPER, ROCK, RES_P1, 1, 0, 4);
        check("maxr_p1_done", match_done, 1'b1);
        check("maxr_p1_winner", match_winner, WIN_P1);

        // All ties -> draw
        pulse_start();
        do_round(ROCK, ROCK, RES_TIE, 0, 0, 1);
        do_round(ROCK, ROCK, RES_TIE, 0, 0, 2);
        do_round(SCISSORS, SCISSORS, RES_TIE, 0, 0, 3);
        do_round(PAPER, PAPER, RES_TIE, 0, 0, 4);
        check("draw_done", match_done, 1'b1);
        check("draw_winner", match_winner, WIN_DRAW);

`ifdef RPS_ROUND_TIMEOUT_EN
        pulse_start();
        p2_move = PAPER; p2_valid = 1'b1;
        tick();
        p2_valid = 1'b0;
        wait_round_done(20);
        check("to_forfeit_result", round_result, RES_P2);
        check("to_forfeit_scores", {p1_score, p2_score, round_count}, 12'h011);
        tick();
        wait_round_done(20);
        check("to_empty_result", round_result, RES_TIE);
        check("to_empty_scores", {p1_score, p2_score, round_count}, 12'h012);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
